// File: rtl/branch_pc_unit_pkg.sv
// =============================================================================
// branch_pc_unit_pkg : shared control-transfer codes and reset fetch address
// Revision: 1.0
// =============================================================================
`default_nettype none

package branch_pc_unit_pkg;

  localparam logic [31:0] C_RESET_PC = 32'h0000_3000;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_BEQ  = 3'd1,
    OP_BNE  = 3'd2,
    OP_J    = 3'd3,
    OP_JAL  = 3'd4,
    OP_JR   = 3'd5
  } id_op_e;

  // Word-offset branch displacement: sign-extend and scale by four.
  function automatic logic [31:0] sext_shift2(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/npc_calc.sv
// =============================================================================
// npc_calc : combinational redirect decision and target address for ID stage
// Revision: 1.0
// =============================================================================
`default_nettype none

module npc_calc
  import branch_pc_unit_pkg::*;
(
  input  logic [2:0]  id_op,
  input  logic        equal,
  input  logic [25:0] index26,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rsdata,
  output logic        redirect,
  output logic [31:0] target
);

  logic [15:0] w_imm16;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;

  assign w_imm16      = index26[15:0];
  assign w_branch_tgt = id_pc + 32'd4 + sext_shift2(w_imm16);
  assign w_jump_tgt   = {id_pc[31:28], index26, 2'b00};

  always_comb begin
    redirect = 1'b0;
    target   = w_branch_tgt;
    case (id_op)
      OP_BEQ: redirect = equal;
      OP_BNE: redirect = ~equal;
      OP_J, OP_JAL: begin
        redirect = 1'b1;
        target   = w_jump_tgt;
      end
      OP_JR: begin
        redirect = 1'b1;
        target   = id_rsdata;
      end
      default: redirect = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_pc_unit.sv
// =============================================================================
// branch_pc_unit : fetch PC, IF/ID register and taken-redirect counter
// Revision: 1.0
// =============================================================================
`default_nettype none

module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Equal,
  input  logic [2:0]  ID_Op,
  input  logic [31:0] ID_RsData,
  input  logic [31:0] IM_Instr,
  output logic [31:0] IF_PC,
  output logic [31:0] ID_Instr,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC8,
  output logic        Redirect,
  output logic [15:0] TakenCnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic        w_redirect;
  logic [31:0] w_target;

  npc_calc u_npc_calc (
    .id_op     (ID_Op),
    .equal     (Equal),
    .index26   (id_instr_q[25:0]),
    .id_pc     (id_pc_q),
    .id_rsdata (ID_RsData),
    .redirect  (w_redirect),
    .target    (w_target)
  );

  // Stall freezes everything, so a held branch is re-decided with fresh inputs.
  always_comb begin
    pc_d        = pc_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    taken_cnt_d = taken_cnt_q;
    if (!Stall) begin
      pc_d       = w_redirect ? w_target : pc_q + 32'd4;
      id_instr_d = IM_Instr;
      id_pc_d    = pc_q;
      if (w_redirect) begin
        taken_cnt_d = taken_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      id_instr_q  <= 32'h0;
      id_pc_q     <= 32'h0;
      taken_cnt_q <= 16'h0;
    end else begin
      pc_q        <= pc_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign IF_PC    = pc_q;
  assign ID_Instr = id_instr_q;
  assign ID_PC    = id_pc_q;
  assign ID_PC8   = id_pc_q + 32'd8;
  assign Redirect = w_redirect;
  assign TakenCnt = taken_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
// =============================================================================
// tb_branch_pc_unit : random and directed stimulus against a behavioural model
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall = 1'b0;
  logic        Equal = 1'b0;
  logic [2:0]  ID_Op = 3'd0;
  logic [31:0] ID_RsData = 32'h0;
  logic [31:0] IM_Instr = 32'h0;
  logic [31:0] IF_PC, ID_Instr, ID_PC, ID_PC8;
  logic        Redirect;
  logic [15:0] TakenCnt;

  int checks = 0;
  int errors = 0;

  branch_pc_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Equal(Equal), .ID_Op(ID_Op),
    .ID_RsData(ID_RsData), .IM_Instr(IM_Instr), .IF_PC(IF_PC),
    .ID_Instr(ID_Instr), .ID_PC(ID_PC), .ID_PC8(ID_PC8),
    .Redirect(Redirect), .TakenCnt(TakenCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural state and the transfer rules in plain arithmetic.
  logic [31:0] m_pc, m_instr, m_idpc;
  int unsigned m_cnt;

  function automatic bit m_taken(input int op, input bit eq);
    return (op == 1 && eq) || (op == 2 && !eq) || op == 3 || op == 4 || op == 5;
  endfunction

  function automatic logic [31:0] m_dest(input int op, input logic [31:0] instr,
                                         input logic [31:0] idpc, input logic [31:0] rs);
    longint disp;
    disp = longint'($signed(instr[15:0])) * 4;
    if (op == 1 || op == 2) return 32'(longint'(idpc) + 4 + disp);
    if (op == 3 || op == 4) return (idpc & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 4);
    return rs;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc    <= 32'h0000_3000;
      m_instr <= 32'h0;
      m_idpc  <= 32'h0;
      m_cnt   <= 0;
    end else if (!Stall) begin
      if (m_taken(int'(ID_Op), Equal)) begin
        m_pc  <= m_dest(int'(ID_Op), m_instr, m_idpc, ID_RsData);
        m_cnt <= (m_cnt + 1) % 65536;
      end else begin
        m_pc <= m_pc + 32'd4;
      end
      m_instr <= IM_Instr;
      m_idpc  <= m_pc;
    end
  end

  always @(negedge clk) begin
    chk("IF_PC", IF_PC, m_pc);
    chk("ID_Instr", ID_Instr, m_instr);
    chk("ID_PC", ID_PC, m_idpc);
    chk("ID_PC8", ID_PC8, m_idpc + 32'd8);
    chk("Redirect", {31'h0, Redirect}, {31'h0, m_taken(int'(ID_Op), Equal)});
    chk("TakenCnt", {16'h0, TakenCnt}, m_cnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    ID_Op = 3'd3;
    IM_Instr = 32'h0000_1234;
    repeat (4) step();

    // Mid-cycle reset must act before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_if_pc", IF_PC, 32'h0000_3000);
    chk("rst_id_instr", ID_Instr, 32'h0);
    chk("rst_cnt", {16'h0, TakenCnt}, 32'h0);
    ID_Op = 3'd0;
    step();
    reset = 1'b0;

    // Taken BEQ from ID_PC=3004 back to 3000.
    IM_Instr = 32'h1111_FFFE;
    step();
    IM_Instr = 32'h2222_FFFE;
    step();
    chk("beq_id_pc", ID_PC, 32'h0000_3004);
    ID_Op = 3'd1; Equal = 1'b1;
    #1 chk("beq_redirect", {31'h0, Redirect}, 32'h1);
    step();
    chk("beq_if_pc", IF_PC, 32'h0000_3000);
    chk("beq_cnt", {16'h0, TakenCnt}, 32'h1);

    // Untaken BNE at ID_PC=3010.
    ID_Op = 3'd0;
    repeat (5) step();
    chk("bne_id_pc", ID_PC, 32'h0000_3010);
    ID_Op = 3'd2; Equal = 1'b1;
    #1 chk("bne_redirect", {31'h0, Redirect}, 32'h0);
    step();
    chk("bne_if_pc", IF_PC, 32'h0000_3018);

    // JR under two stalled cycles with a changing rs value.
    ID_Op = 3'd5; Stall = 1'b1; ID_RsData = 32'h0000_4000;
    step();
    chk("jr_hold1", IF_PC, 32'h0000_3018);
    ID_RsData = 32'h0000_5000;
    step();
    chk("jr_hold2", IF_PC, 32'h0000_3018);
    Stall = 1'b0;
    step();
    chk("jr_if_pc", IF_PC, 32'h0000_5000);
    chk("jr_cnt", {16'h0, TakenCnt}, 32'h2);

    // JAL from A000_3000 with index 0x400; delay-slot word must reach ID.
    ID_RsData = 32'hA000_3000;
    step();
    ID_Op = 3'd0;
    IM_Instr = 32'h0C00_0400;
    step();
    IM_Instr = 32'hDEAD_BEEF;
    chk("jal_id_pc", ID_PC, 32'hA000_3000);
    ID_Op = 3'd4;
    #1 chk("jal_pc8", ID_PC8, 32'hA000_3008);
    step();
    chk("jal_if_pc", IF_PC, 32'hA000_1000);
    chk("jal_slot", ID_Instr, 32'hDEAD_BEEF);
    chk("jal_cnt", {16'h0, TakenCnt}, 32'h4);

    // Reset while a taken jump is pending, then counter wrap.
    ID_Op = 3'd3;
    #2 reset = 1'b1;
    step();
    reset = 1'b0;
    #1 chk("rst_pending_pc", IF_PC, 32'h0000_3000);
    repeat (65535) step();
    chk("wrap_ffff", {16'h0, TakenCnt}, 32'h0000_FFFF);
    step();
    chk("wrap_zero", {16'h0, TakenCnt}, 32'h0);

    // Random traffic, including all op codes and occasional mid-cycle reset.
    for (int i = 0; i < 3000; i++) begin
      ID_Op     = 3'($urandom_range(0, 7));
      Equal     = 1'($urandom);
      Stall     = ($urandom_range(0, 3) == 0);
      ID_RsData = $urandom;
      IM_Instr  = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
